// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: mode and FSM state encodings shared by the LED pattern generator.
package led_pattern_pkg;
  typedef enum logic [1:0] {
    MODE_COUNT   = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_BOUNCE  = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;
  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_PENDING = 1'b1
  } state_t;
endpackage

// File: rtl/led_step_prescaler.sv
// led_step_prescaler: registered step pulse every step_div+1 cycles.
module led_step_prescaler #(
  parameter int PRESCALE_WIDTH = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PRESCALE_WIDTH-1:0] step_div,
  output logic                      step_tick
);
  logic [PRESCALE_WIDTH-1:0] r_cnt;
  logic                      r_tick;
  logic                      w_hit;
  // >= rather than == so a lowered step_div fires at once instead of wrapping
  assign w_hit     = r_cnt >= step_div;
  assign step_tick = r_tick;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_hit ? '0 : r_cnt + PRESCALE_WIDTH'(1);
      r_tick <= w_hit;
    end
  end
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: COUNT/CHASE/BOUNCE/BREATHE LED patterns with a mode handshake.
// LED_PATTERN_BREATHE_EN enables the PWM breathe mode; otherwise mode 3 runs COUNT.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int LED_COUNT      = 16,
  parameter int PRESCALE_WIDTH = 24,
  parameter int PWM_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PRESCALE_WIDTH-1:0] step_div,
  input  logic [1:0]                mode,
  input  logic                      mode_valid,
  output logic                      mode_ready,
  output logic [LED_COUNT-1:0]      led,
  output logic                      step_tick
);
  state_t               r_state;
  mode_t                r_mode, r_pend, w_next_mode;
  logic                 r_ready, r_dir;
  logic [LED_COUNT-1:0] r_led, w_step, w_bounce;
  logic                 w_tick, w_apply, w_accept, w_dir_next, w_pwm_on;

  led_step_prescaler #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .step_div  (step_div),
    .step_tick (w_tick)
  );

  assign step_tick  = w_tick;
  assign mode_ready = r_ready;
  assign led        = r_led;
  assign w_accept   = mode_valid && r_ready;
  assign w_apply    = w_tick && (r_state == ST_PENDING);

  // the lit endpoint reverses direction in the same step, so it is never held twice
  assign w_dir_next = r_dir ^ (r_dir ? r_led[0] : r_led[LED_COUNT-1]);
  assign w_bounce   = w_dir_next ? r_led >> 1 : r_led << 1;
  assign w_step     = (r_mode == MODE_COUNT) ? r_led + LED_COUNT'(1) :
                      (r_mode == MODE_CHASE) ? {r_led[LED_COUNT-2:0], r_led[LED_COUNT-1]} :
                      w_bounce;

`ifdef LED_PATTERN_BREATHE_EN
  logic [PWM_WIDTH-1:0] r_pwm, r_duty;
  logic                 r_ddir, w_ddir_next;
  assign w_next_mode = r_pend;
  assign w_pwm_on    = r_pwm < r_duty;
  assign w_ddir_next = r_ddir ^ (r_ddir ? (r_duty == '0) : (&r_duty));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pwm  <= '0;
      r_duty <= '0;
      r_ddir <= 1'b0;
    end else begin
      r_pwm <= r_pwm + PWM_WIDTH'(1);
      if (w_apply) begin
        r_duty <= '0;
        r_ddir <= 1'b0;
      end else if (w_tick && r_mode == MODE_BREATHE) begin
        r_duty <= w_ddir_next ? r_duty - PWM_WIDTH'(1) : r_duty + PWM_WIDTH'(1);
        r_ddir <= w_ddir_next;
      end
    end
  end
`else
  assign w_next_mode = (r_pend == MODE_BREATHE) ? MODE_COUNT : r_pend;
  assign w_pwm_on    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_ready <= 1'b1;
      r_pend  <= MODE_COUNT;
    end else if (w_accept) begin
      r_state <= ST_PENDING;
      r_ready <= 1'b0;
      r_pend  <= mode_t'(mode);
    end else if (w_apply) begin
      r_state <= ST_RUN;
      r_ready <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode <= MODE_COUNT;
      r_led  <= '0;
      r_dir  <= 1'b0;
    end else if (w_apply) begin
      r_mode <= w_next_mode;
      r_led  <= (w_next_mode == MODE_CHASE || w_next_mode == MODE_BOUNCE) ? LED_COUNT'(1) : '0;
      r_dir  <= 1'b0;
    end else if (r_mode == MODE_BREATHE) begin
      r_led <= {LED_COUNT{w_pwm_on}};
    end else if (w_tick) begin
      r_led <= w_step;
      r_dir <= (r_mode == MODE_BOUNCE) ? w_dir_next : r_dir;
    end
  end
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed + random stimulus checked against a step-count reference model.
module tb_led_pattern_gen;
  localparam int N  = 4;
  localparam int PW = 8;
  localparam int WW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] step_div = '0;
  logic [1:0]    mode = '0;
  logic          mode_valid = 1'b0;
  logic          mode_ready, step_tick;
  logic [N-1:0]  led;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  led_pattern_gen #(.LED_COUNT(N), .PRESCALE_WIDTH(PW), .PWM_WIDTH(WW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .step_div   (step_div),
    .mode       (mode),
    .mode_valid (mode_valid),
    .mode_ready (mode_ready),
    .led        (led),
    .step_tick  (step_tick)
  );

  int           m_cnt, m_k, m_pwm, m_mode, m_pend;
  bit           m_tick, m_pending;
  logic [N-1:0] m_led;

  // pattern after k steps, from closed-form rules
  function automatic logic [N-1:0] pat(input int md, input int k);
    int p;
    if (md == 1) return N'(1) << (k % N);
    if (md == 2) begin
      p = k % (2 * N - 2);
      return N'(1) << ((p < N) ? p : 2 * N - 2 - p);
    end
    return N'(k % (1 << N));
  endfunction

  function automatic int duty(input int k);
    int m, q;
    m = (1 << WW) - 1;
    q = k % (2 * m);
    return (q <= m) ? q : 2 * m - q;
  endfunction

  function automatic int norm(input int md);
`ifdef LED_PATTERN_BREATHE_EN
    return md;
`else
    return (md == 3) ? 0 : md;
`endif
  endfunction

  always @(posedge clk) begin
    bit apply, accept;
    if (!rst_n) begin
      m_cnt = 0; m_k = 0; m_pwm = 0; m_mode = 0; m_pend = 0;
      m_tick = 0; m_pending = 0; m_led = '0;
    end else begin
      apply  = m_tick && m_pending;
      accept = mode_valid && !m_pending;
      if (apply) begin
        m_mode = norm(m_pend);
        m_k    = 0;
        m_led  = (m_mode == 3) ? '0 : pat(m_mode, 0);
      end else if (m_mode == 3) begin
        m_led = (m_pwm < duty(m_k)) ? '1 : '0;
        if (m_tick) m_k++;
      end else if (m_tick) begin
        m_k++;
        m_led = pat(m_mode, m_k);
      end
      if (accept) begin
        m_pending = 1;
        m_pend    = int'(mode);
      end else if (apply) m_pending = 0;
      m_tick = (m_cnt >= int'(step_div));
      m_cnt  = m_tick ? 0 : m_cnt + 1;
      m_pwm  = (m_pwm + 1) % (1 << WW);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check("led", 64'(led), 64'(m_led));
    check("mode_ready", 64'(mode_ready), 64'(!m_pending));
    check("step_tick", 64'(step_tick), 64'(m_tick));
  endtask

  task automatic req(input int md);
    mode = 2'(md);
    mode_valid = 1'b1;
    cyc();
    mode_valid = 1'b0;
  endtask

  initial begin
    step_div = 8'd3;
    cyc(); cyc();
    rst_n = 1'b1;
    repeat (20) cyc();
    step_div = 8'd0;
    req(1); repeat (10) cyc();
    req(2); repeat (12) cyc();
    step_div = 8'd9;
    req(1);
    mode = 2'd2; mode_valid = 1'b1;
    repeat (30) cyc();
    mode_valid = 1'b0;
    repeat (20) cyc();
    step_div = 8'd15;
    req(3); repeat (150) cyc();
    step_div = 8'd9;
    req(1); cyc(); cyc();
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    repeat (30) cyc();
    repeat (3000) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 19) == 0) step_div = PW'($urandom_range(0, 12));
      mode = 2'($urandom_range(0, 3));
      mode_valid = ($urandom_range(0, 3) == 0);
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter LED_COUNT, default 16: number of LED outputs; legal range 2..64.
REQ-002 Parameter PRESCALE_WIDTH, default 24: width of the step prescaler counter and of step_div.
REQ-003 Parameter PWM_WIDTH, default 8: width of the breathe-mode PWM counter and duty register.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 step_div  input  PRESCALE_WIDTH  step period minus one, in clk cycles; sampled every cycle.
REQ-007 mode  input  2  requested pattern: 0 COUNT, 1 CHASE, 2 BOUNCE, 3 BREATHE.
REQ-008 mode_valid  input  1  mode request present.
REQ-009 mode_ready  output  1  block can accept a mode request.
REQ-010 led  output  LED_COUNT  registered LED drive.
REQ-011 step_tick  output  1  one-cycle pulse on every prescaler step.

Function
REQ-012 The prescaler shall increment each cycle and, when count >= step_div, assert step_tick for that cycle and return to 0; step_div=0 gives step_tick every cycle.
REQ-013 Lowering step_div below the current count shall produce step_tick on the next cycle (no wrap through 2^PRESCALE_WIDTH).
REQ-014 COUNT: a LED_COUNT-bit counter shall increment on each step_tick, wrap from all-ones to 0; led = counter.
REQ-015 CHASE: a single set bit shall rotate left on each step_tick; bit LED_COUNT-1 wraps to bit 0.
REQ-016 BOUNCE: a single set bit shall move left per step_tick until bit LED_COUNT-1, then right until bit 0, then left; endpoint bits are each lit once per reversal (no double dwell).
REQ-017 BREATHE: duty shall step +1 per step_tick up to all-ones, then -1 down to 0, triangle; a free-running PWM_WIDTH counter increments every clk; all led bits = (pwm_cnt < duty).
REQ-018 led shall be registered: pattern change caused by step_tick at cycle N is visible on led at cycle N+1.
REQ-019 Handshake: request accepted when mode_valid && mode_ready; mode_ready shall fall the cycle after acceptance.
REQ-020 Accepted mode shall be held pending and applied on the first step_tick strictly after the acceptance cycle; mode_ready shall return high the cycle after that tick.
REQ-021 On applying a mode, pattern state initialises: COUNT counter=0; CHASE and BOUNCE bit 0 set, direction left; BREATHE duty=0, direction up.
REQ-022 Re-requesting the current mode shall restart it per REQ-021.
REQ-023 mode and mode_valid shall be ignored while mode_ready is low.
REQ-024 The state machine shall be two states: RUN (mode_ready=1) and PENDING (mode_ready=0); RUN->PENDING on acceptance, PENDING->RUN on step_tick.

Reset
REQ-025 rst_n low at a rising clk edge shall set led=0, step_tick=0, mode_ready=1, state RUN, active mode COUNT, counter=0, prescaler=0, pwm_cnt=0, duty=0, direction up/left.
REQ-026 Reset asserted mid-operation or while PENDING shall discard any pending mode.

Configuration
REQ-027 Macro LED_PATTERN_BREATHE_EN defined: BREATHE mode, PWM counter and duty logic present per REQ-017.
REQ-028 Macro undefined: no PWM/duty logic; mode 3 shall be accepted and behave exactly as COUNT.

Structure
REQ-029 Package led_pattern_pkg shall hold the 2-bit mode typedef/constants (MODE_COUNT, MODE_CHASE, MODE_BOUNCE, MODE_BREATHE) and state encodings.
REQ-030 Prescaler shall be a sub-module led_step_prescaler (inputs clk, rst_n, step_div; output step_tick).

Verification
REQ-031 Reset release, step_div=3, no requests -> step_tick every 4th cycle; led shows 0,1,2,3... one cycle after each tick.
REQ-032 LED_COUNT=4, step_div=0, CHASE request -> after apply, led = 0001,0010,0100,1000,0001.
REQ-033 LED_COUNT=4, step_div=0, BOUNCE -> led = 0001,0010,0100,1000,0100,0010,0001,0010.
REQ-034 step_div=9, request CHASE then hold mode_valid with BOUNCE -> mode_ready low 1 cycle after accept until 1 cycle after next tick; BOUNCE ignored until ready returns.
REQ-035 PWM_WIDTH=2, BREATHE, step_div=15 -> duty 0,1,2,3,2,1,0; with duty=2 led all-ones for 2 of every 4 cycles; without macro same stimulus gives COUNT output.
REQ-036 rst_n low for 1 cycle while PENDING -> led=0, mode_ready=1, mode COUNT, pending request lost.
